// File: rtl/disp_stream_rx.sv
// Disparity stream receiver: takes 2-pixel beats (VSYNC/HSYNC/DATA_0/DATA_1),
// buffers them in a small pixel FIFO and re-emits one pixel per cycle on a
// valid/ready port tagged with x/y coordinates and end-of-line/frame flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for VSYNC; HSYNC beats are ignored
// ACTIVE | accepting beats until WIDTH*HEIGHT/2 have been counted
// DRAIN  | all beats counted; extra beats are errors; wait for m_eof pop

module disp_stream_rx #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       VSYNC,
   input  logic       HSYNC,
   input  logic [7:0] DATA_0,
   input  logic [7:0] DATA_1,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic [8:0] m_x,
   output logic [7:0] m_y,
   output logic       m_eol,
   output logic       m_eof,
   output logic       frame_done,
   output logic       err_overflow,
   output logic       err_frame
);

   localparam int TOTAL_BEATS = WIDTH * HEIGHT / 2;
   localparam int BW          = $clog2(TOTAL_BEATS + 1);
   localparam int AW          = $clog2(FIFO_DEPTH);
   localparam int PW          = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [BW-1:0]   beat_cnt;
   logic [8:0]      nx;
   logic [7:0]      ny;

   logic [PW-1:0]   fifo_cnt;
   logic [PW-1:0]   cnt_eff;
   logic [PW-1:0]   wr_base;
   logic [PW-1:0]   rd_base;
   logic [AW-1:0]   wr_idx0;
   logic [AW-1:0]   wr_idx1;
   logic [BW-1:0]   beat_base;
   logic [BW-1:0]   beat_next;
   logic            beat_in;
   logic            push;
   logic            drop;
   logic            load;
   logic            handshake;
   logic            eof_hs;
   logic            last_beat;
   logic            frame_incomplete;

   // Push/pop decisions; VSYNC flushes the FIFO and counters before any
   // beat that arrives in the same cycle is considered.
   always_comb begin
      fifo_cnt         = wr_ptr - rd_ptr;
      handshake        = m_valid & m_ready;
      eof_hs           = handshake & m_eof;
      wr_base          = VSYNC ? '0 : wr_ptr;
      rd_base          = VSYNC ? '0 : rd_ptr;
      cnt_eff          = VSYNC ? '0 : fifo_cnt;
      beat_base        = VSYNC ? '0 : beat_cnt;
      beat_next        = beat_base + BW'(1);
      beat_in          = HSYNC & (VSYNC | (state == S_ACTIVE));
      push             = beat_in & (cnt_eff <= PW'(FIFO_DEPTH - 2));
      drop             = beat_in & ~push;
      last_beat        = beat_in & (beat_next == BW'(TOTAL_BEATS));
      load             = ~VSYNC & (fifo_cnt != '0) & (~m_valid | m_ready);
      wr_idx0          = wr_base[AW-1:0];
      wr_idx1          = wr_idx0 + AW'(1);
      frame_incomplete = ((state == S_ACTIVE) & (beat_cnt != '0)) |
                         ((state == S_DRAIN) & ~eof_hs);
   end

   // Pixel storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge HCLK) begin
      if (push) begin
         mem[wr_idx0] <= DATA_0;
         mem[wr_idx1] <= DATA_1;
      end
   end

   // FIFO pointers (one extra bit distinguishes full from empty).
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_base + (push ? PW'(2) : PW'(0));
         rd_ptr <= rd_base + (load ? PW'(1) : PW'(0));
      end
   end

   // Output register stage: holds the head pixel and its coordinates until
   // accepted; nx/ny track the coordinates of the next pixel to be loaded.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_x     <= '0;
         m_y     <= '0;
         m_eol   <= 1'b0;
         m_eof   <= 1'b0;
         nx      <= '0;
         ny      <= '0;
      end else if (VSYNC) begin
         m_valid <= 1'b0;
         m_x     <= '0;
         m_y     <= '0;
         m_eol   <= 1'b0;
         m_eof   <= 1'b0;
         nx      <= '0;
         ny      <= '0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= mem[rd_ptr[AW-1:0]];
         m_x     <= nx;
         m_y     <= ny;
         m_eol   <= (nx == 9'(WIDTH - 1));
         m_eof   <= (nx == 9'(WIDTH - 1)) && (ny == 8'(HEIGHT - 1));
         if (nx == 9'(WIDTH - 1)) begin
            nx <= '0;
            ny <= (ny == 8'(HEIGHT - 1)) ? 8'd0 : ny + 8'd1;
         end else begin
            nx <= nx + 9'd1;
         end
      end else if (handshake) begin
         m_valid <= 1'b0;
      end
   end

   // Frame sequencing, input beat counter, completion pulse and sticky errors.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state        <= S_IDLE;
         beat_cnt     <= '0;
         frame_done   <= 1'b0;
         err_overflow <= 1'b0;
         err_frame    <= 1'b0;
      end else begin
         frame_done <= (state == S_DRAIN) & eof_hs;
         beat_cnt   <= beat_in ? beat_next : beat_base;
         if (drop)
            err_overflow <= 1'b1;
         if ((VSYNC & frame_incomplete) | ((state == S_DRAIN) & HSYNC & ~VSYNC))
            err_frame <= 1'b1;
         if (VSYNC) begin
            state <= last_beat ? S_DRAIN : S_ACTIVE;
         end else begin
            case (state)
               S_IDLE:   state <= S_IDLE;
               S_ACTIVE: if (last_beat) state <= S_DRAIN;
               S_DRAIN:  if (eof_hs) state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/disp_stream_rx.md
Name: disp_stream_rx

Overview:
- Synthesizable receiver for the 2-pixel-per-beat disparity stream (VSYNC, HSYNC, DATA_0, DATA_1) driven by the disparity engines.
- Buffers each beat in a pixel FIFO and re-emits the stream one pixel per cycle on a valid/ready interface, tagged with x/y coordinates and end-of-line/end-of-frame flags.
- Sits between the disparity core and downstream consumers (frame buffer, display, DMA), replacing the simulation-only writer in hardware builds.

Parameters:
- WIDTH, 320, pixels per line (even).
- HEIGHT, 240, lines per frame.
- FIFO_DEPTH, 16, FIFO capacity in pixels (power of two, >=4).

Ports:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- VSYNC  in  1  one-cycle frame-start strobe, asserted before the first beat of a frame.
- HSYNC  in  1  beat valid; DATA_0/DATA_1 are sampled when high.
- DATA_0  in  8  pixel at even x.
- DATA_1  in  8  pixel at x+1.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  8  pixel value.
- m_x  out  9  column of m_data (0..WIDTH-1).
- m_y  out  8  row of m_data (0..HEIGHT-1).
- m_eol  out  1  m_data is the last pixel of its line.
- m_eof  out  1  m_data is the last pixel of the frame.
- frame_done  out  1  one-cycle pulse after the m_eof pixel is accepted.
- err_overflow  out  1  sticky; a beat was dropped because the FIFO was full.
- err_frame  out  1  sticky; VSYNC arrived mid-frame, or a beat arrived beyond WIDTH*HEIGHT pixels.

Behaviour:
- Reset (async, HRESETn=0): FIFO empty; all counters 0; state IDLE; m_valid=0; m_data=0; m_x=0; m_y=0; m_eol=0; m_eof=0; frame_done=0; err_overflow=0; err_frame=0.
- Sticky error flags clear only on reset.
- State machine:
  - IDLE: HSYNC ignored; VSYNC -> ACTIVE with input beat counter=0.
  - ACTIVE: an accepted beat pushes DATA_0 and then DATA_1 (DATA_0 first out). When the input counter reaches WIDTH*HEIGHT/2 beats -> DRAIN.
  - DRAIN: HSYNC beats are dropped and set err_frame. After the m_eof pixel handshakes -> IDLE, and frame_done pulses on the next cycle.
- Push rule: a beat is written only if free space >= 2. Otherwise both pixels are dropped, err_overflow is set, and the input beat counter still advances, so the frame still ends.
- Output: m_valid = FIFO not empty. m_data, m_x, m_y, m_eol, m_eof are registered and held stable while m_valid=1 and m_ready=0. A pixel pops on m_valid & m_ready.
- Latency: a pixel pushed at edge N is visible with m_valid=1 after edge N+1.
- FIFO throughput: push (2 pixels) and pop (1 pixel) in the same cycle are both legal; occupancy +1. Sustained HSYNC every cycle therefore fills the FIFO.
- Output coordinates: m_x increments per popped pixel and wraps WIDTH-1 -> 0, incrementing m_y. m_y wraps HEIGHT-1 -> 0. m_eol = (m_x==WIDTH-1). m_eof = m_eol & (m_y==HEIGHT-1).
- Dropped pixels do not advance m_x/m_y; coordinates reflect delivered order only, which err_overflow flags.
- VSYNC while ACTIVE or DRAIN (resync):
  - Set err_frame if the frame was incomplete.
  - Flush the FIFO, reset the input counter and m_x/m_y to 0, deassert m_valid next cycle, enter ACTIVE.
  - No frame_done for the aborted frame.
- VSYNC and HSYNC in the same cycle: VSYNC handling first, then the beat is accepted as the first beat of the new frame.
- Counter widths: input beat counter ceil(log2(WIDTH*HEIGHT/2+1)) bits; FIFO pointers log2(FIFO_DEPTH)+1 bits for full/empty detection.

Test Plan:
- Reset, VSYNC, 4 beats (0x10/0x11, 0x12/0x13, ...) with m_ready=1 -> m_data 0x10,0x11,0x12,... in order; m_x 0..7; m_y=0; first m_valid one cycle after the first beat.
- Full 320x240 frame of 38400 beats, HSYNC every other cycle, m_ready=1 -> 76800 pixels; m_eol at m_x=319 each line; m_eof with m_y=239; single frame_done pulse; both error flags 0.
- m_ready=0 with HSYNC every cycle, FIFO_DEPTH=16 -> 8 beats accepted; the 9th beat dropped; err_overflow=1; m_data held at the first pixel; m_x=0.
- VSYNC after 100 beats of a frame -> err_frame=1; FIFO flushed; next popped pixel has m_x=0, m_y=0 and equals DATA_0 of the first post-VSYNC beat.
- HSYNC beats before any VSYNC, and beat 38401 after a complete frame -> no output from the pre-VSYNC beats; the extra beat sets err_frame; no extra pixel.
- HRESETn asserted mid-frame with the FIFO half full -> all outputs 0 immediately; after release, HSYNC is ignored until VSYNC.
